imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
- Registered immediate-generation stage sitting between fetch and decode/execute.
- Accepts 32-bit RV32I instructions on a valid/ready interface and decodes every immediate format (I, S, B, U, J), plus R-type and no-immediate classes.
- Buffers results in a 2-entry skid buffer, so the upstream ready signal is fully registered.
- Flags unsupported opcodes and keeps a saturating count of delivered illegal instructions.

Parameters:
- DWIDTH, 32, width of out_imm; must be >= 32 (checked by immediate assertion).
- CNT_WIDTH, 16, width of the illegal-instruction counter; must be >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous buffer clear.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept; registered.
- in_instr  input  32 (instr_t)  instruction word.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- out_instr  output  32 (instr_t)  instruction passthrough.
- out_imm  output  DWIDTH  sign/zero-extended immediate.
- out_fmt  output  3 (imm_fmt_t)  format: FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z, FMT_NONE.
- out_illegal  output  1  opcode unsupported.
- illegal_cnt  output  CNT_WIDTH  saturating count of delivered illegal entries.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Decode (combinational on in_instr; result captured at push):
  - OP_IMM, LOAD, JALR → FMT_I, imm = sext(instr[31:20]).
  - STORE → FMT_S, imm = sext({[31:25],[11:7]}).
  - BRANCH → FMT_B, imm = sext({[31],[7],[30:25],[11:8],1'b0}).
  - JAL → FMT_J, imm = sext({[31],[19:12],[20],[30:21],1'b0}).
  - LUI, AUIPC → FMT_U, imm = sext({[31:12],12'b0}).
  - OP → FMT_R, imm = 0.
  - MISC_MEM → FMT_NONE, imm = 0.
  - Any other opcode → FMT_NONE, imm = 0, out_illegal = 1. Never output X.
- Sign extension always replicates instr[31] up to DWIDTH.
- Handshake:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - out_* are held stable while out_valid & !out_ready.
  - Latency is 1 cycle: an entry pushed in cycle N is presented in cycle N+1.
- Occupancy FSM, states EMPTY, ONE, TWO:
  - EMPTY: push → ONE.
  - ONE:
    - push & !pop → TWO (new entry goes to skid).
    - pop & !push → EMPTY.
    - push & pop → ONE (main register reloaded).
  - TWO: pop → ONE (skid moves to main); push is impossible.
  - out_valid = (state != EMPTY).
  - in_ready is registered as (next_state != TWO).
  - FIFO order is always preserved.
- Flush:
  - State goes to EMPTY next cycle.
  - A same-cycle push is discarded.
  - Flushed entries are not counted.
  - flush has no effect on illegal_cnt.
- Counter:
  - illegal_cnt increments on pop & out_illegal.
  - Saturates at all-ones and does not wrap.
  - Cleared only by rst.
- Reset:
  - state EMPTY; out_valid = 0; in_ready = 0 while rst is asserted, 1 the first cycle after.
  - out_instr, out_imm, illegal_cnt = 0; out_fmt = FMT_NONE; out_illegal = 0.
  - Reset mid-transfer drops all buffered entries.

Optional Feature:
- Macro IMM_ZICSR_EN.
- When defined, SYSTEM opcode is legal:
  - funct3[2] = 1 (CSRR*I) → FMT_Z, imm = zero-extended instr[19:15].
  - funct3[2] = 0 → FMT_I, imm = zero-extended instr[31:20] (CSR address).
- When undefined, SYSTEM is illegal (FMT_NONE, imm 0, out_illegal 1).
- FMT_Z always exists in imm_fmt_t; it is simply never produced without the macro.

Decomposition:
- typedefs_pkg gains:
  - imm_fmt_t enum (3 bits).
  - Opcode constants LUI, AUIPC, OP, MISC_MEM, SYSTEM, alongside existing ones.
  - U-type view in instr_t if it is not already present.
- One combinational sub-module, imm_format_decoder (instr in → imm, fmt, illegal out), instantiated once at the input.
- The skid-buffer FSM lives in imm_decode_stage itself.

Test Plan:
- addi 0xFFF00093, out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=FMT_I, out_illegal=0.
- Format sweep:
  - lui 0x123452B7 → imm 0x12345000, FMT_U.
  - beq 0xFE000EE3 → imm 0xFFFFFFFC, FMT_B.
  - jal 0x008000EF → imm 0x00000008, FMT_J.
  - DWIDTH=64 lui → imm 0x0000000012345000.
- Backpressure:
  - out_ready=0, three back-to-back pushes A, B, C → A and B accepted, in_ready low from the cycle after B, C stalls.
  - Then out_ready=1 → A, B, C delivered in order with no duplication.
- Illegal counter: CNT_WIDTH=2, five pops of 0x0000007F → out_illegal=1, imm 0, illegal_cnt = 1, 2, 3, 3, 3.
- Flush and reset:
  - State TWO plus flush with simultaneous in_valid → next cycle out_valid=0, nothing delivered, counter unchanged.
  - rst mid-stream → all outputs at reset values.
- Optional feature: csrrwi 0x3005D073 → with IMM_ZICSR_EN imm 0x0000000B, FMT_Z; without it out_illegal=1, FMT_NONE.

Source files
------------

// File: rtl/imm_decode_stage_pkg.sv
// Shared types for the immediate-generation stage: RV32I opcode constants,
// an instruction word with I-type and U-type views, and the immediate format enum.
package imm_decode_stage_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_NONE = 3'd7
    } imm_fmt_t;

    typedef struct packed {
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } instr_i_t;

    typedef struct packed {
        logic [19:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } instr_u_t;

    typedef union packed {
        logic [31:0] raw;
        instr_i_t    i;
        instr_u_t    u;
    } instr_t;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Valid/ready bundle between fetch and the immediate stage, plus the result bus.
// master: the stage side (drives in_ready and all out_* results).
// slave:  the surrounding pipeline (drives instructions and out_ready).
interface imm_decode_stage_if
    import imm_decode_stage_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) ();

    logic              in_valid;
    logic              in_ready;
    instr_t            in_instr;
    logic              out_valid;
    logic              out_ready;
    instr_t            out_instr;
    logic [DWIDTH-1:0] out_imm;
    imm_fmt_t          out_fmt;
    logic              out_illegal;

    modport master (
        input  in_valid,
        output in_ready,
        input  in_instr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_imm,
        output out_fmt,
        output out_illegal
    );

    modport slave (
        output in_valid,
        input  in_ready,
        output in_instr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_imm,
        input  out_fmt,
        input  out_illegal
    );

endinterface

// File: rtl/imm_format_decoder.sv
// Combinational RV32I immediate decoder: instruction word in, extended immediate,
// format class and illegal-opcode flag out. Every path yields a defined value.
// Optional macro IMM_ZICSR_EN makes SYSTEM legal (CSR address / zimm decode).
module imm_format_decoder
    import imm_decode_stage_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  instr_t            instr,
    output logic [DWIDTH-1:0] imm,
    output imm_fmt_t          fmt,
    output logic              illegal
);

    logic [31:0] r;
    assign r = instr.raw;

    // Widen a 32-bit immediate whose bit 31 already carries instr[31].
    function automatic logic [DWIDTH-1:0] sext32(input logic [31:0] v);
        return DWIDTH'($signed(v));
    endfunction

    // Opcode decode with safe defaults for anything unsupported.
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (instr.i.opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                fmt = FMT_I;
                imm = sext32({{20{r[31]}}, r[31:20]});
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = sext32({{20{r[31]}}, r[31:25], r[11:7]});
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = sext32({{20{r[31]}}, r[7], r[30:25], r[11:8], 1'b0});
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = sext32({{12{r[31]}}, r[19:12], r[20], r[30:21], 1'b0});
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = sext32({instr.u.imm, 12'b0});
            end
            OPC_OP: begin
                fmt = FMT_R;
            end
            OPC_MISC_MEM: begin
                fmt = FMT_NONE;
            end
            OPC_SYSTEM: begin
`ifdef IMM_ZICSR_EN
                // funct3[2] selects the immediate-operand CSR forms.
                if (instr.i.funct3[2]) begin
                    fmt = FMT_Z;
                    imm = DWIDTH'(instr.i.rs1);
                end else begin
                    fmt = FMT_I;
                    imm = DWIDTH'(instr.i.imm);
                end
`else
                illegal = 1'b1;
`endif
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer so that
// in_ready comes straight from a flop. Keeps a saturating count of illegal
// instructions handed downstream.
// Optional macro IMM_ZICSR_EN (in imm_format_decoder): decode SYSTEM as legal.
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    imm_decode_stage_if.master   bus,
    output logic [CNT_WIDTH-1:0] illegal_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_t;

    state_t            state_q, state_d;
    logic              in_ready_q;
    logic              push, pop;
    logic              load_main_in, load_main_skid, load_skid;

    logic [DWIDTH-1:0] dec_imm;
    imm_fmt_t          dec_fmt;
    logic              dec_illegal;

    instr_t            main_instr_q, skid_instr_q;
    logic [DWIDTH-1:0] main_imm_q, skid_imm_q;
    imm_fmt_t          main_fmt_q, skid_fmt_q;
    logic              main_illegal_q, skid_illegal_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    imm_format_decoder #(
        .DWIDTH (DWIDTH)
    ) u_dec (
        .instr   (bus.in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign push = bus.in_valid & in_ready_q;
    assign pop  = (state_q != StEmpty) & bus.out_ready;

    // Occupancy next-state and which buffer slot each transfer writes.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_d      = StOne;
                        load_main_in = 1'b1;
                    end
                end
                StOne: begin
                    if (push && !pop) begin
                        state_d   = StTwo;
                        load_skid = 1'b1;
                    end else if (pop && !push) begin
                        state_d = StEmpty;
                    end else if (push && pop) begin
                        load_main_in = 1'b1;
                    end
                end
                StTwo: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        state_d        = StOne;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    // State, registered ready, buffer slots and the illegal counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (DWIDTH >= 32 && CNT_WIDTH >= 1)
                else $error("imm_decode_stage: DWIDTH must be >= 32 and CNT_WIDTH >= 1");
            state_q        <= StEmpty;
            in_ready_q     <= 1'b0;
            main_instr_q   <= '0;
            main_imm_q     <= '0;
            main_fmt_q     <= FMT_NONE;
            main_illegal_q <= 1'b0;
            skid_instr_q   <= '0;
            skid_imm_q     <= '0;
            skid_fmt_q     <= FMT_NONE;
            skid_illegal_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StTwo);
            if (load_main_in) begin
                main_instr_q   <= bus.in_instr;
                main_imm_q     <= dec_imm;
                main_fmt_q     <= dec_fmt;
                main_illegal_q <= dec_illegal;
            end else if (load_main_skid) begin
                main_instr_q   <= skid_instr_q;
                main_imm_q     <= skid_imm_q;
                main_fmt_q     <= skid_fmt_q;
                main_illegal_q <= skid_illegal_q;
            end
            if (load_skid) begin
                skid_instr_q   <= bus.in_instr;
                skid_imm_q     <= dec_imm;
                skid_fmt_q     <= dec_fmt;
                skid_illegal_q <= dec_illegal;
            end
            // Only entries actually delivered are counted; flush leaves it alone.
            if (pop && main_illegal_q && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = (state_q != StEmpty);
    assign bus.out_instr   = main_instr_q;
    assign bus.out_imm     = main_imm_q;
    assign bus.out_fmt     = main_fmt_q;
    assign bus.out_illegal = main_illegal_q;
    assign illegal_cnt     = cnt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: a 32-bit/16-bit-counter instance and a
// 64-bit/2-bit-counter instance driven from one linear stimulus sequence.
module tb_imm_decode_stage;
    import imm_decode_stage_pkg::*;

    logic clk;
    logic rst;
    logic flush;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int checks = 0;
    int errors = 0;

    imm_decode_stage_if #(.DWIDTH(32)) bus0 ();
    imm_decode_stage_if #(.DWIDTH(64)) bus1 ();

    imm_decode_stage #(
        .DWIDTH    (32),
        .CNT_WIDTH (16)
    ) dut0 (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus0),
        .illegal_cnt (cnt0)
    );

    imm_decode_stage #(
        .DWIDTH    (64),
        .CNT_WIDTH (2)
    ) dut1 (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus1),
        .illegal_cnt (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic push0(input logic [31:0] ins);
        bus0.in_valid = 1'b1;
        bus0.in_instr = ins;
        step();
        bus0.in_valid = 1'b0;
    endtask

    task automatic push1(input logic [31:0] ins);
        bus1.in_valid = 1'b1;
        bus1.in_instr = ins;
        step();
        bus1.in_valid = 1'b0;
    endtask

    task automatic expect0(input string tag, input logic [31:0] imm, input imm_fmt_t fmt,
                           input logic ill);
        check({tag, ".valid"}, 64'(bus0.out_valid), 64'd1);
        check({tag, ".imm"}, 64'(bus0.out_imm), 64'(imm));
        check({tag, ".fmt"}, 64'(bus0.out_fmt), 64'(fmt));
        check({tag, ".illegal"}, 64'(bus0.out_illegal), 64'(ill));
    endtask

    localparam logic [31:0] I_ADDI  = 32'hFFF00093;
    localparam logic [31:0] I_LUI   = 32'h123452B7;
    localparam logic [31:0] I_LUIN  = 32'h800000B7;
    localparam logic [31:0] I_BEQ   = 32'hFE000EE3;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_SW    = 32'hFE112C23;
    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_FENCE = 32'h0FF0000F;
    localparam logic [31:0] I_CSRWI = 32'h3005D073;
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    initial begin
        int exp_cnt1 [5];
        logic [15:0] exp_cnt0;
        exp_cnt1 = '{1, 2, 3, 3, 3};

        rst = 1'b1;
        flush = 1'b0;
        bus0.in_valid = 1'b0;
        bus0.in_instr = '0;
        bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.in_instr = '0;
        bus1.out_ready = 1'b0;
        step();
        step();

        // Reset values while rst is held.
        check("rst.in_ready", 64'(bus0.in_ready), 64'd0);
        check("rst.out_valid", 64'(bus0.out_valid), 64'd0);
        check("rst.out_instr", 64'(bus0.out_instr), 64'd0);
        check("rst.out_imm", 64'(bus0.out_imm), 64'd0);
        check("rst.out_fmt", 64'(bus0.out_fmt), 64'(FMT_NONE));
        check("rst.out_illegal", 64'(bus0.out_illegal), 64'd0);
        check("rst.cnt", 64'(cnt0), 64'd0);

        rst = 1'b0;
        step();
        check("post_rst.in_ready", 64'(bus0.in_ready), 64'd1);
        check("post_rst.out_valid", 64'(bus0.out_valid), 64'd0);

        // Format sweep on the 32-bit instance, one entry per cycle.
        bus0.out_ready = 1'b1;
        push0(I_ADDI);
        expect0("addi", 32'hFFFFFFFF, FMT_I, 1'b0);
        check("addi.instr", 64'(bus0.out_instr), 64'(I_ADDI));
        push0(I_LUI);
        expect0("lui", 32'h12345000, FMT_U, 1'b0);
        push0(I_BEQ);
        expect0("beq", 32'hFFFFFFFC, FMT_B, 1'b0);
        push0(I_JAL);
        expect0("jal", 32'h00000008, FMT_J, 1'b0);
        push0(I_SW);
        expect0("sw", 32'hFFFFFFF8, FMT_S, 1'b0);
        push0(I_ADD);
        expect0("add", 32'h0, FMT_R, 1'b0);
        push0(I_FENCE);
        expect0("fence", 32'h0, FMT_NONE, 1'b0);
        push0(I_CSRWI);
`ifdef IMM_ZICSR_EN
        expect0("csrrwi", 32'h0000000B, FMT_Z, 1'b0);
        exp_cnt0 = 16'd1;
`else
        expect0("csrrwi", 32'h0, FMT_NONE, 1'b1);
        exp_cnt0 = 16'd2;
`endif
        push0(I_BAD);
        expect0("bad", 32'h0, FMT_NONE, 1'b1);
        step();
        check("sweep.drained", 64'(bus0.out_valid), 64'd0);
        check("sweep.cnt", 64'(cnt0), 64'(exp_cnt0));

        // 64-bit instance: sign extension all the way to bit 63.
        bus1.out_ready = 1'b1;
        push1(I_LUI);
        check("w64.lui.imm", bus1.out_imm, 64'h0000000012345000);
        push1(I_LUIN);
        check("w64.luin.imm", bus1.out_imm, 64'hFFFFFFFF80000000);
        push1(I_BEQ);
        check("w64.beq.imm", bus1.out_imm, 64'hFFFFFFFFFFFFFFFC);
        step();

        // Two-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            push1(I_BAD);
            check("cnt.illegal", 64'(bus1.out_illegal), 64'd1);
            check("cnt.imm", bus1.out_imm, 64'd0);
            step();
            check("cnt.value", 64'(cnt1), 64'(exp_cnt1[i]));
        end

        // Backpressure: A and B buffered, C stalls, then in-order drain.
        bus0.out_ready = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.in_instr = I_ADDI;
        step();
        check("bp.a.in_ready", 64'(bus0.in_ready), 64'd1);
        check("bp.a.instr", 64'(bus0.out_instr), 64'(I_ADDI));
        bus0.in_instr = I_LUI;
        step();
        check("bp.b.in_ready", 64'(bus0.in_ready), 64'd0);
        check("bp.b.instr", 64'(bus0.out_instr), 64'(I_ADDI));
        bus0.in_instr = I_JAL;
        step();
        check("bp.c.in_ready", 64'(bus0.in_ready), 64'd0);
        check("bp.c.valid", 64'(bus0.out_valid), 64'd1);
        check("bp.c.instr", 64'(bus0.out_instr), 64'(I_ADDI));
        check("bp.c.imm", 64'(bus0.out_imm), 64'hFFFFFFFF);
        bus0.out_ready = 1'b1;
        step();
        check("bp.d1.instr", 64'(bus0.out_instr), 64'(I_LUI));
        check("bp.d1.imm", 64'(bus0.out_imm), 64'h12345000);
        check("bp.d1.in_ready", 64'(bus0.in_ready), 64'd1);
        step();
        bus0.in_valid = 1'b0;
        check("bp.d2.instr", 64'(bus0.out_instr), 64'(I_JAL));
        check("bp.d2.valid", 64'(bus0.out_valid), 64'd1);
        step();
        check("bp.d3.valid", 64'(bus0.out_valid), 64'd0);
        check("bp.cnt", 64'(cnt0), 64'(exp_cnt0));

        // Flush from TWO with a simultaneous in_valid.
        bus0.out_ready = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.in_instr = I_BAD;
        step();
        step();
        check("fl.two.in_ready", 64'(bus0.in_ready), 64'd0);
        check("fl.two.valid", 64'(bus0.out_valid), 64'd1);
        flush = 1'b1;
        step();
        check("fl.valid", 64'(bus0.out_valid), 64'd0);
        check("fl.in_ready", 64'(bus0.in_ready), 64'd1);
        flush = 1'b0;
        bus0.in_valid = 1'b0;
        bus0.out_ready = 1'b1;
        step();
        check("fl.after.valid", 64'(bus0.out_valid), 64'd0);
        check("fl.cnt", 64'(cnt0), 64'(exp_cnt0));

        // Flush from ONE discards a push offered in the same cycle.
        bus0.out_ready = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.in_instr = I_BAD;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus0.in_valid = 1'b0;
        check("fl1.valid", 64'(bus0.out_valid), 64'd0);
        bus0.out_ready = 1'b1;
        step();
        check("fl1.after.valid", 64'(bus0.out_valid), 64'd0);
        check("fl1.cnt", 64'(cnt0), 64'(exp_cnt0));

        // Reset with two entries buffered.
        bus0.out_ready = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.in_instr = I_LUI;
        step();
        step();
        check("mid.two.valid", 64'(bus0.out_valid), 64'd1);
        rst = 1'b1;
        bus0.in_valid = 1'b0;
        step();
        check("mid.rst.valid", 64'(bus0.out_valid), 64'd0);
        check("mid.rst.in_ready", 64'(bus0.in_ready), 64'd0);
        check("mid.rst.instr", 64'(bus0.out_instr), 64'd0);
        check("mid.rst.imm", 64'(bus0.out_imm), 64'd0);
        check("mid.rst.fmt", 64'(bus0.out_fmt), 64'(FMT_NONE));
        check("mid.rst.illegal", 64'(bus0.out_illegal), 64'd0);
        check("mid.rst.cnt0", 64'(cnt0), 64'd0);
        check("mid.rst.cnt1", 64'(cnt1), 64'd0);
        rst = 1'b0;
        bus0.out_ready = 1'b1;
        step();
        check("mid.after.in_ready", 64'(bus0.in_ready), 64'd1);
        check("mid.after.valid", 64'(bus0.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
